// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: immediate formats, RV32I opcodes and the encoder request type.
package imm_encoder_pkg;
   typedef enum logic [2:0] {
      Imm_I = 3'd0,
      Imm_S = 3'd1,
      Imm_B = 3'd2,
      Imm_U = 3'd3,
      Imm_J = 3'd4,
      Imm_R = 3'd5
   } ImmSel_t;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6f;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;

   typedef struct packed {
      ImmSel_t     sel;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } enc_req_t;

   // true when v[31:lsb] is a pure sign extension
   function automatic logic sx_ok(input logic [31:0] v, input int unsigned lsb);
      logic [31:0] t;
      t = $signed(v) >>> lsb;
      return (t == '0) || (t == '1);
   endfunction
endpackage

// File: rtl/imm_encoder_pack.sv
// imm_pack: combinational RV32I word packing; range check only with IMM_RANGE_CHK_EN.
module imm_pack
   import imm_encoder_pkg::*;
(
   input  enc_req_t    req,
   output logic [31:0] inst,
   output logic        err
);
   logic [31:0] m;
   assign m = req.imm;

   always_comb begin
      inst = '0;
      case (req.sel)
         Imm_I:   inst = {m[11:0], req.rs1, req.funct3, req.rd, req.opcode};
         Imm_S:   inst = {m[11:5], req.rs2, req.rs1, req.funct3, m[4:0], req.opcode};
         Imm_B:   inst = {m[12], m[10:5], req.rs2, req.rs1, req.funct3, m[4:1], m[11], req.opcode};
         Imm_U:   inst = {m[31:12], req.rd, req.opcode};
         Imm_J:   inst = {m[20], m[10:1], m[11], m[19:12], req.rd, req.opcode};
         default: inst = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      endcase
   end

`ifdef IMM_RANGE_CHK_EN
   always_comb begin
      err = 1'b0;
      case (req.sel)
         Imm_I, Imm_S: err = !sx_ok(m, 11);
         Imm_B:        err = !sx_ok(m, 12) || m[0];
         Imm_J:        err = !sx_ok(m, 20) || m[0];
         Imm_U:        err = |m[11:0];
         default:      err = 1'b0;
      endcase
   end
`else
   assign err = 1'b0;
`endif
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: 2-stage valid/ready RV32I instruction builder with saturating counters.
// Optional range check on the immediate when IMM_RANGE_CHK_EN is defined.
module imm_encoder
   import imm_encoder_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  ImmSel_t          in_sel,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [2:0]       in_funct3,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_cnt,
   output logic [CNT_W-1:0] err_cnt
);
   enc_req_t    s1_req;
   logic        s1_v, s2_v, s2_ready;
   logic [31:0] pk_inst;
   logic        pk_err;

   assign s2_ready  = !s2_v || out_ready;
   assign in_ready  = !s1_v || s2_ready;
   assign out_valid = s2_v;

   imm_pack u_pack (.req(s1_req), .inst(pk_inst), .err(pk_err));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v   <= 1'b0;
         s1_req <= '0;
      end else if (in_ready) begin
         s1_v <= in_valid;
         if (in_valid)
            s1_req <= '{sel: in_sel, opcode: in_opcode, rd: in_rd, funct3: in_funct3,
                        rs1: in_rs1, rs2: in_rs2, funct7: in_funct7, imm: in_imm};
      end
   end

   // output register holds its word while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v     <= 1'b0;
         out_inst <= '0;
         out_err  <= 1'b0;
      end else if (s2_ready) begin
         s2_v <= s1_v;
         if (s1_v) begin
            out_inst <= pk_inst;
            out_err  <= pk_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_cnt <= '0;
         err_cnt <= '0;
      end else if (out_valid && out_ready) begin
         if (!(&enc_cnt)) enc_cnt <= enc_cnt + CNT_W'(1);
         if (out_err && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
      end
   end
endmodule
